// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: car-park gate front end.
//   Entry and exit loop sensors are synchronised and debounced, and each
//   lane runs its own gate FSM. Completed passages become single-cycle
//   car_enter / car_exit pulses for the occupancy counter. The two pulses
//   never coincide. An entry request made while the counter reports full
//   is refused with a deny pulse.
//
// Optional build macro: GATE_TIMEOUT_EN
//   When defined, OPEN waits at most TIMEOUT_CYCLES. After that, a car
//   still on the loop is tracked in PASSING until it clears.
//
// Ports:
//   clk            block clock (same divided clock as the occupancy counter)
//   reset          asynchronous reset, active low
//   entry_sensor   raw entry-lane loop detector, 1 = car present
//   exit_sensor    raw exit-lane loop detector, 1 = car present
//   full           occupancy counter at capacity
//   car_enter      1-cycle pulse: one car entered
//   car_exit       1-cycle pulse: one car left
//   gate_in_open   entry barrier open command (registered)
//   gate_out_open  exit barrier open command (registered)
//   deny           1-cycle pulse: entry refused because full

// Per-lane sensor conditioning and gate FSM.
//   sensor  raw loop detector
//   full    capacity flag; tie to 0 for a lane that never refuses
//   gate    registered barrier command, 1 in OPEN/PASSING/HOLD
//   passed  1-cycle strobe, coincident with the first HOLD cycle
//   deny    1-cycle strobe, request refused
module parking_gate_lane #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16
`ifdef GATE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  input  logic full,
  output logic gate,
  output logic passed,
  output logic deny
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    PASSING = 2'd2,
    HOLD    = 2'd3
  } state_t;

  logic [1:0]  sync_q;
  logic        lvl_q;
  logic [7:0]  deb_cnt;
  state_t      state_q, state_n;
  logic [15:0] hold_cnt;
  logic        blocked_q;
  logic        passed_n, deny_n, block_set;
  logic        hold_done, admit;

  // 2-flop synchroniser, then debounce. The level flips only after
  // DEB_CYCLES consecutive samples disagree with it. Any agreeing sample
  // restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], sensor};
      if (sync_q[1] != lvl_q) begin
        if (deb_cnt == 8'(DEB_CYCLES - 1)) begin
          lvl_q   <= sync_q[1];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // The FSM works on the debounced level instead of its edges. A high
  // level in IDLE/HOLD can only follow a rise, because OPEN always leaves
  // on a fall. After a deny the lane is blocked until the level drops,
  // so a car that waits on the loop is not re-evaluated.
  assign admit     = lvl_q && !blocked_q;
  assign hold_done = (hold_cnt == 16'(HOLD_CYCLES - 1));

`ifdef GATE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_done;
  assign to_done = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_n   = state_q;
    passed_n  = 1'b0;
    deny_n    = 1'b0;
    block_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (admit) begin
          if (full) begin
            deny_n    = 1'b1;
            block_set = 1'b1;
          end else begin
            state_n = OPEN;
          end
        end
      end
      // With a single loop, the fall is itself the passage.
      OPEN: begin
        if (!lvl_q) begin
          state_n  = HOLD;
          passed_n = 1'b1;
        end
`ifdef GATE_TIMEOUT_EN
        else if (to_done) begin
          state_n = PASSING;
        end
`endif
      end
`ifdef GATE_TIMEOUT_EN
      PASSING: begin
        if (!lvl_q) begin
          state_n  = HOLD;
          passed_n = 1'b1;
        end
      end
`endif
      HOLD: begin
        state_n = hold_done ? IDLE : HOLD;
        // A new car reopens without dropping the gate. A refusal here
        // leaves the hold timer running.
        if (admit) begin
          if (full) begin
            deny_n    = 1'b1;
            block_set = 1'b1;
          end else begin
            state_n = OPEN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gate      <= 1'b0;
      passed    <= 1'b0;
      deny      <= 1'b0;
      blocked_q <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_n;
      gate      <= (state_n != IDLE);
      passed    <= passed_n;
      deny      <= deny_n;
      blocked_q <= block_set | (blocked_q & lvl_q);
      hold_cnt  <= (state_q == HOLD && state_n == HOLD) ? hold_cnt + 16'd1 : '0;
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= (state_q == OPEN && state_n == OPEN) ? to_cnt + 1'b1 : '0;
    end
  end
`endif

endmodule

module parking_gate_ctrl #(
  parameter int DEB_CYCLES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_sensor,
  input  logic exit_sensor,
  input  logic full,
  output logic car_enter,
  output logic car_exit,
  output logic gate_in_open,
  output logic gate_out_open,
  output logic deny
);

  localparam int NUM_LANES = 2;  // lane 0 = entry, lane 1 = exit

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || HOLD_CYCLES < 1 ||
      HOLD_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("parking_gate_ctrl: parameter out of range");
  end

  logic [NUM_LANES-1:0] sensor, lane_full, lane_gate, lane_passed, lane_deny;

  assign sensor    = {exit_sensor, entry_sensor};
  assign lane_full = {1'b0, full};  // the exit lane never refuses

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    parking_gate_lane #(
      .DEB_CYCLES    (DEB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES)
`ifdef GATE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .sensor(sensor[g]),
      .full  (lane_full[g]),
      .gate  (lane_gate[g]),
      .passed(lane_passed[g]),
      .deny  (lane_deny[g])
    );
  end

  assign gate_in_open  = lane_gate[0];
  assign gate_out_open = lane_gate[1];
  assign deny          = |lane_deny;  // only lane 0 can raise it

  // Pulse arbiter. A pending enter always goes out first. An exit that
  // collides with it is held for one cycle instead. Two passages on the
  // same lane are many cycles apart (debounce + reopen), so each pending
  // flag never has to hold more than one event.
  logic pend_enter_q, pend_exit_q;
  logic pend_enter_n, pend_exit_n, enter_n, exit_n;

  always_comb begin
    enter_n      = 1'b0;
    exit_n       = 1'b0;
    pend_enter_n = pend_enter_q;
    pend_exit_n  = pend_exit_q;
    if (pend_enter_q) begin
      enter_n      = 1'b1;
      pend_enter_n = lane_passed[0];
      pend_exit_n  = pend_exit_q | lane_passed[1];
    end else if (pend_exit_q || lane_passed[1]) begin
      exit_n       = 1'b1;
      pend_exit_n  = 1'b0;
      pend_enter_n = lane_passed[0];
    end else if (lane_passed[0]) begin
      enter_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      car_enter    <= 1'b0;
      car_exit     <= 1'b0;
      pend_enter_q <= 1'b0;
      pend_exit_q  <= 1'b0;
    end else begin
      car_enter    <= enter_n;
      car_exit     <= exit_n;
      pend_enter_q <= pend_enter_n;
      pend_exit_q  <= pend_exit_n;
    end
  end

endmodule
